// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single unified memory port of the multi-cycle MIPS core.
// Round-robin between CPU and DMA, variable-latency memory via mem_ack, bounded by a timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              owner_r, owner_s;
  logic              last_grant_r, last_grant_s;
  logic              win_dma_s;
  logic              mem_req_r, mem_req_s;
  logic              mem_we_r, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic              cpu_ack_r, cpu_ack_s, cpu_err_r, cpu_err_s;
  logic              dma_ack_r, dma_ack_s, dma_err_r, dma_err_s;
  logic              busy_r, busy_s;

  // Next-state and next-output logic; acks are computed on the way into DONE so they appear registered.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    win_dma_s    = 1'b0;
    mem_req_s    = mem_req_r;
    mem_we_s     = mem_we_r;
    mem_addr_s   = mem_addr_r;
    mem_wdata_s  = mem_wdata_r;
    rdata_s      = rdata_r;
    cpu_ack_s    = 1'b0;
    cpu_err_s    = 1'b0;
    dma_ack_s    = 1'b0;
    dma_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          if (cpu_req && dma_req) begin
            win_dma_s = (last_grant_r == GRANT_CPU);
          end else begin
            win_dma_s = dma_req;
          end
          owner_s      = win_dma_s ? GRANT_DMA : GRANT_CPU;
          last_grant_s = owner_s;
          mem_req_s    = 1'b1;
          mem_we_s     = win_dma_s ? dma_we    : cpu_we;
          mem_addr_s   = win_dma_s ? dma_addr  : cpu_addr;
          mem_wdata_s  = win_dma_s ? dma_wdata : cpu_wdata;
          cnt_s        = '0;
          state_s      = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // mem_ack is checked first so a completion on the last allowed cycle is not an error
        if (mem_ack) begin
          if (!mem_we_r) begin
            rdata_s = mem_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          mem_req_s = 1'b0;
          cpu_ack_s = (owner_r == GRANT_CPU);
          dma_ack_s = (owner_r == GRANT_DMA);
          state_s   = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          rdata_s   = '0;
          mem_req_s = 1'b0;
          cpu_ack_s = (owner_r == GRANT_CPU);
          cpu_err_s = (owner_r == GRANT_CPU);
          dma_ack_s = (owner_r == GRANT_DMA);
          dma_err_s = (owner_r == GRANT_DMA);
          state_s   = ST_DONE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s   = ST_IDLE;
        mem_req_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset abandons any in-flight access and biases the first contention to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      owner_r      <= GRANT_CPU;
      last_grant_r <= GRANT_DMA;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      rdata_r      <= '0;
      cpu_ack_r    <= 1'b0;
      cpu_err_r    <= 1'b0;
      dma_ack_r    <= 1'b0;
      dma_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      mem_req_r    <= mem_req_s;
      mem_we_r     <= mem_we_s;
      mem_addr_r   <= mem_addr_s;
      mem_wdata_r  <= mem_wdata_s;
      rdata_r      <= rdata_s;
      cpu_ack_r    <= cpu_ack_s;
      cpu_err_r    <= cpu_err_s;
      dma_ack_r    <= dma_ack_s;
      dma_err_r    <= dma_err_s;
      busy_r       <= busy_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign rdata     = rdata_r;
  assign cpu_ack   = cpu_ack_r;
  assign cpu_err   = cpu_err_r;
  assign dma_ack   = dma_ack_r;
  assign dma_err   = dma_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a per-cycle vector table plus directed
// sequences for timeout, last-cycle ack, async reset and round-robin contention.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic        cpu_ack, cpu_err, dma_ack, dma_err, mem_req, mem_we, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cycle     = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err),
    .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_cpu_ack;
    logic        e_dma_ack;
    logic [31:0] e_rdata;
    logic        e_busy;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    int n;
    int last_ack_cycle;
    logic exp_dma;

    vecs[0]  = '{1'b1,1'b0,32'h40,32'h0,   1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,
                 1'b1,1'b0,32'h40,32'h0,   1'b0,1'b0,32'h0,1'b1};
    vecs[1]  = '{1'b1,1'b0,32'h40,32'h0,   1'b0,1'b0,32'h0,32'h0,   1'b1,32'hDEADBEEF,
                 1'b0,1'b0,32'h40,32'h0,   1'b1,1'b0,32'hDEADBEEF,1'b1};
    vecs[2]  = '{1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,
                 1'b0,1'b0,32'h40,32'h0,   1'b0,1'b0,32'hDEADBEEF,1'b0};
    vecs[3]  = '{1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h0,32'h0,   1'b1,32'h11111111,
                 1'b0,1'b0,32'h40,32'h0,   1'b0,1'b0,32'hDEADBEEF,1'b0};
    vecs[4]  = '{1'b1,1'b1,32'h80,32'h1234, 1'b0,1'b0,32'h0,32'h0,  1'b0,32'h0,
                 1'b1,1'b1,32'h80,32'h1234, 1'b0,1'b0,32'hDEADBEEF,1'b1};
    vecs[5]  = '{1'b1,1'b1,32'hFFC,32'h9999, 1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0,
                 1'b1,1'b1,32'h80,32'h1234, 1'b0,1'b0,32'hDEADBEEF,1'b1};
    vecs[6]  = '{1'b1,1'b1,32'hFFC,32'h9999, 1'b0,1'b0,32'h0,32'h0, 1'b1,32'hAAAAAAAA,
                 1'b0,1'b1,32'h80,32'h1234, 1'b1,1'b0,32'hDEADBEEF,1'b1};
    vecs[7]  = '{1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,
                 1'b0,1'b1,32'h80,32'h1234, 1'b0,1'b0,32'hDEADBEEF,1'b0};
    vecs[8]  = '{1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,32'h200,32'h77, 1'b0,32'h0,
                 1'b1,1'b0,32'h200,32'h77,  1'b0,1'b0,32'hDEADBEEF,1'b1};
    vecs[9]  = '{1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,32'h200,32'h77, 1'b1,32'h0BADF00D,
                 1'b0,1'b0,32'h200,32'h77,  1'b0,1'b1,32'h0BADF00D,1'b1};
    vecs[10] = '{1'b0,1'b0,32'h0,32'h0,    1'b0,1'b0,32'h0,32'h0,   1'b0,32'h0,
                 1'b0,1'b0,32'h200,32'h77,  1'b0,1'b0,32'h0BADF00D,1'b0};

    idle_inputs();
    rst = 1'b1;
    step();
    step();
    chk("rst_mem_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},  32'd0);
    chk("rst_mem_addr",  mem_addr,  32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata",     rdata,     32'd0);
    chk("rst_busy",      {31'd0, busy},    32'd0);
    chk("rst_acks",      {28'd0, cpu_ack, cpu_err, dma_ack, dma_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table: inputs applied before an edge, outputs checked just after it
    for (int i = 0; i < 11; i++) begin
      cpu_req = vecs[i].cpu_req; cpu_we = vecs[i].cpu_we;
      cpu_addr = vecs[i].cpu_addr; cpu_wdata = vecs[i].cpu_wdata;
      dma_req = vecs[i].dma_req; dma_we = vecs[i].dma_we;
      dma_addr = vecs[i].dma_addr; dma_wdata = vecs[i].dma_wdata;
      mem_ack = vecs[i].mem_ack; mem_rdata = vecs[i].mem_rdata;
      step();
      chk($sformatf("v%0d_mem_req", i),   {31'd0, mem_req}, {31'd0, vecs[i].e_mem_req});
      chk($sformatf("v%0d_mem_we", i),    {31'd0, mem_we},  {31'd0, vecs[i].e_mem_we});
      chk($sformatf("v%0d_mem_addr", i),  mem_addr,  vecs[i].e_mem_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      chk($sformatf("v%0d_cpu_ack", i),   {31'd0, cpu_ack}, {31'd0, vecs[i].e_cpu_ack});
      chk($sformatf("v%0d_dma_ack", i),   {31'd0, dma_ack}, {31'd0, vecs[i].e_dma_ack});
      chk($sformatf("v%0d_errs", i),      {30'd0, cpu_err, dma_err}, 32'd0);
      chk($sformatf("v%0d_rdata", i),     rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_busy", i),      {31'd0, busy}, {31'd0, vecs[i].e_busy});
    end

    // mem_ack on the 16th (last allowed) ACCESS cycle: success, data captured
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h300;
    step();
    chk("tmb_grant_addr", mem_addr, 32'h300);
    for (int k = 0; k < 15; k++) step();
    chk("tmb_still_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    chk("tmb_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    chk("tmb_cpu_err", {31'd0, cpu_err}, 32'd0);
    chk("tmb_rdata",   rdata, 32'hCAFEF00D);
    idle_inputs();
    step();
    chk("tmb_idle", {31'd0, busy}, 32'd0);

    // DMA write with no mem_ack: timeout after exactly 16 ACCESS cycles
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h55;
    step();
    chk("to_mem_addr",  mem_addr,  32'h100);
    chk("to_mem_wdata", mem_wdata, 32'h55);
    n = (mem_req === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40 && mem_req === 1'b1; k++) begin
      step();
      if (mem_req === 1'b1) n++;
    end
    chk("to_req_cycles", n, 32'd16);
    chk("to_dma_ack",  {31'd0, dma_ack}, 32'd1);
    chk("to_dma_err",  {31'd0, dma_err}, 32'd1);
    chk("to_cpu_side", {30'd0, cpu_ack, cpu_err}, 32'd0);
    chk("to_rdata",    rdata, 32'd0);
    idle_inputs();
    step();
    chk("to_idle", {29'd0, busy, dma_ack, dma_err}, 32'd0);

    // Async reset mid-ACCESS after a CPU grant, then contention must go to CPU first
    cpu_req = 1'b1; cpu_addr = 32'h500;
    step();
    step();
    chk("rs_in_access", {31'd0, mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rs_busy",    {31'd0, busy},    32'd0);
    chk("rs_acks",    {28'd0, cpu_ack, cpu_err, dma_ack, dma_err}, 32'd0);
    chk("rs_addr",    mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 32'h1000;
    dma_req = 1'b1; dma_addr = 32'h2000;

    // Continuous contention, memory acks on the 3rd ACCESS cycle: CPU, DMA, CPU, DMA
    last_ack_cycle = -1;
    for (int g = 0; g < 4; g++) begin
      exp_dma = (g % 2 == 1);
      step();
      chk($sformatf("rr%0d_mem_req", g),  {31'd0, mem_req}, 32'd1);
      chk($sformatf("rr%0d_mem_addr", g), mem_addr, exp_dma ? 32'h2000 : 32'h1000);
      step();
      step();
      mem_ack = 1'b1; mem_rdata = 32'h100 + g;
      step();
      mem_ack = 1'b0;
      chk($sformatf("rr%0d_cpu_ack", g), {31'd0, cpu_ack}, exp_dma ? 32'd0 : 32'd1);
      chk($sformatf("rr%0d_dma_ack", g), {31'd0, dma_ack}, exp_dma ? 32'd1 : 32'd0);
      chk($sformatf("rr%0d_rdata", g),   rdata, 32'h100 + g);
      if (last_ack_cycle >= 0) begin
        chk($sformatf("rr%0d_spacing", g), cycle - last_ack_cycle, 32'd5);
      end
      last_ack_cycle = cycle;
      step();
      chk($sformatf("rr%0d_ack_drop", g), {30'd0, cpu_ack, dma_ack}, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
